// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared parameters, FSM states and tag type for the systolic sequencer
package systolic_pkg;
  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int ARR_LAT = 2 * N - 1;
  localparam int CW      = 8;
  localparam int WCW     = $clog2(N);

  typedef enum logic [2:0] {IDLE, LOAD_W, SETTLE, STREAM, DRAIN, DONE} state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;
endpackage

// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - config, weight/activation streams, array and result ports of the sequencer
interface systolic_ctrl_if;
  import systolic_pkg::*;

  logic          cfg_start;
  logic [CW-1:0] cfg_nrows;
  logic          w_valid;
  logic          w_ready;
  logic [N*DW-1:0] w_data;
  logic          a_valid;
  logic          a_ready;
  logic [N*DW-1:0] a_data;
  logic [N*DW-1:0] sa_a;
  logic [N*DW-1:0] sa_b;
  logic          sa_switch;
  logic [N*DW-1:0] sa_ans;
  logic          res_valid;
  logic [N*DW-1:0] res_data;
  logic          res_last;
  logic          busy;
  logic          done;

  modport master (
    output cfg_start, cfg_nrows, w_valid, w_data, a_valid, a_data, sa_ans,
    input  w_ready, a_ready, sa_a, sa_b, sa_switch, res_valid, res_data, res_last, busy, done
  );

  modport slave (
    input  cfg_start, cfg_nrows, w_valid, w_data, a_valid, a_data, sa_ans,
    output w_ready, a_ready, sa_a, sa_b, sa_switch, res_valid, res_data, res_last, busy, done
  );
endinterface

// File: rtl/sa_valid_pipe.sv
// rtl/sa_valid_pipe.sv - fixed-depth {valid,last} shift register tracking activations through the array
module sa_valid_pipe #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last,
  output logic any_valid
);
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;

  always_comb begin
    valid_d = {valid_q[DEPTH-2:0], in_valid};
    last_d  = {last_q[DEPTH-2:0], in_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];
  assign any_valid = |valid_q;
endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - loads a weight tile, streams a job of activation rows and returns tagged array results
module systolic_ctrl
  import systolic_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.slave bus
);
  state_e          state_q;
  logic [CW-1:0]   nrows_q;
  logic [CW-1:0]   issued_q;
  logic [WCW-1:0]  wcnt_q;
  logic [N*DW-1:0] sa_a_q, sa_b_q, res_data_q;
  logic            sa_switch_q, w_ready_q, a_ready_q, busy_q, done_q;
  logic            res_valid_q, res_last_q;
  tag_t            tag_q;
  logic            pipe_out_valid, pipe_out_last, pipe_any;
  logic            w_fire, a_fire, last_row;

  assign w_fire   = bus.w_valid & w_ready_q;
  assign a_fire   = bus.a_valid & a_ready_q;
  assign last_row = (issued_q == nrows_q - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nrows_q     <= '0;
      issued_q    <= '0;
      wcnt_q      <= '0;
      sa_a_q      <= '0;
      sa_b_q      <= '0;
      sa_switch_q <= 1'b0;
      w_ready_q   <= 1'b0;
      a_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tag_q       <= '0;
    end else begin
      done_q <= 1'b0;
      tag_q  <= '0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_start) begin
            nrows_q     <= bus.cfg_nrows;
            issued_q    <= '0;
            wcnt_q      <= '0;
            w_ready_q   <= 1'b1;
            sa_switch_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            sa_b_q <= bus.w_data;
            wcnt_q <= wcnt_q + WCW'(1);
            if (wcnt_q == WCW'(N - 1)) begin
              w_ready_q <= 1'b0;
              state_q   <= SETTLE;
            end
          end
        end
        SETTLE: begin
          sa_switch_q <= 1'b0;
          sa_b_q      <= '0;
          if (nrows_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            a_ready_q <= 1'b1;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          // Bubble cycles still push an empty tag so the tracker stays aligned with sa_a.
          sa_a_q     <= a_fire ? bus.a_data : '0;
          tag_q.valid <= a_fire;
          tag_q.last  <= a_fire & last_row;
          if (a_fire) begin
            issued_q <= issued_q + CW'(1);
            if (last_row) begin
              a_ready_q <= 1'b0;
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          sa_a_q <= '0;
          if (!pipe_any && !tag_q.valid) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // tag_q sits alongside sa_a, so the pipe output lines up with the cycle sa_ans is valid.
  sa_valid_pipe #(.DEPTH(ARR_LAT)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tag_q.valid),
    .in_last   (tag_q.last),
    .out_valid (pipe_out_valid),
    .out_last  (pipe_out_last),
    .any_valid (pipe_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= pipe_out_valid;
      res_last_q  <= pipe_out_valid & pipe_out_last;
      res_data_q  <= pipe_out_valid ? bus.sa_ans : '0;
    end
  end

  assign bus.w_ready   = w_ready_q;
  assign bus.a_ready   = a_ready_q;
  assign bus.sa_a      = sa_a_q;
  assign bus.sa_b      = sa_b_q;
  assign bus.sa_switch = sa_switch_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_last  = res_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
